// File: rtl/am2910_pkg.sv
// Shared definitions for the am2910 microprogram sequencer: opcode encoding
// and default widths.
package am2910_pkg;
  localparam int AM_WIDTH = 12;
  localparam int AM_DEPTH = 5;

  typedef enum logic [3:0] {
    JZ   = 4'd0,
    CJS  = 4'd1,
    JMAP = 4'd2,
    CJP  = 4'd3,
    PUSH = 4'd4,
    JSRP = 4'd5,
    CJV  = 4'd6,
    JRP  = 4'd7,
    RFCT = 4'd8,
    RPCT = 4'd9,
    CRTN = 4'd10,
    CJPP = 4'd11,
    LDCT = 4'd12,
    LOOP = 4'd13,
    CONT = 4'd14,
    TWB  = 4'd15
  } op_e;
endpackage

// File: rtl/am2910_stack.sv
// Return-address LIFO. A push into a full stack overwrites the last entry;
// a pop from an empty stack is ignored and top then reads entry 0.
module am2910_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

  logic [SPW-1:0]                sp;
  logic [DEPTH-1:0][WIDTH-1:0]   mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp  <= '0;
      mem <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (push) begin
      if (sp == SP_MAX) begin
        mem[DEPTH-1] <= din;
      end else begin
        mem[sp] <= din;
        sp      <= sp + 1'b1;
      end
    end else if (pop && (sp != '0)) begin
      sp <= sp - 1'b1;
    end
  end

  assign top  = (sp == '0) ? mem[0] : mem[sp - 1'b1];
  assign full = (sp == SP_MAX);
endmodule

// File: rtl/am2910.sv
// Am2910-style microprogram sequencer: selects the next microaddress from
// D, R, uPC or the return stack and maintains those registers.
module am2910
  import am2910_pkg::*;
#(
  parameter int WIDTH = AM_WIDTH,
  parameter int DEPTH = AM_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       I,
  input  logic [WIDTH-1:0] D,
  input  logic             CCEN_n,
  input  logic             CC_n,
  input  logic             RLD_n,
  input  logic             CI,
  input  logic             OE_n,
  output logic [WIDTH-1:0] Y,
  output logic             FULL_n,
  output logic             PL_n,
  output logic             MAP_n,
  output logic             VECT_n
);
  logic [WIDTH-1:0] upc_q, r_q, y_int, top;
  logic             pass, r_nz, full;
  logic             push, pop, clr, r_ld, r_dec;

  assign pass = CCEN_n | ~CC_n;
  assign r_nz = |r_q;

  always_comb begin
    y_int = upc_q;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    r_ld  = 1'b0;
    r_dec = 1'b0;
    unique case (op_e'(I))
      JZ:   begin y_int = '0; clr = 1'b1; end
      CJS:  if (pass) begin y_int = D; push = 1'b1; end
      JMAP: y_int = D;
      CJP:  if (pass) y_int = D;
      PUSH: begin push = 1'b1; r_ld = pass; end
      JSRP: begin y_int = pass ? D : r_q; push = 1'b1; end
      CJV:  if (pass) y_int = D;
      JRP:  y_int = pass ? D : r_q;
      RFCT: if (r_nz) begin y_int = top; r_dec = 1'b1; end
            else pop = 1'b1;
      RPCT: if (r_nz) begin y_int = D; r_dec = 1'b1; end
      CRTN: if (pass) begin y_int = top; pop = 1'b1; end
      CJPP: if (pass) begin y_int = D; pop = 1'b1; end
      LDCT: r_ld = 1'b1;
      LOOP: if (pass) pop = 1'b1;
            else y_int = top;
      CONT: ;
      TWB: begin
        // Three-way branch: loop on top while R counts, fall out to D at zero.
        if (pass) begin
          pop   = 1'b1;
          r_dec = r_nz;
        end else if (r_nz) begin
          y_int = top;
          r_dec = 1'b1;
        end else begin
          y_int = D;
          pop   = 1'b1;
        end
      end
    endcase
  end

  // External RLD_n load wins over any opcode-driven load or decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc_q <= '0;
      r_q   <= '0;
    end else begin
      upc_q <= y_int + WIDTH'(CI);
      if (!RLD_n || r_ld) r_q <= D;
      else if (r_dec)     r_q <= r_q - 1'b1;
    end
  end

  am2910_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (clr),
    .din   (upc_q),
    .top   (top),
    .full  (full)
  );

  assign Y      = OE_n ? 'z : y_int;
  assign FULL_n = ~full;
  assign PL_n   = (I == JMAP) || (I == CJV);
  assign MAP_n  = (I != JMAP);
  assign VECT_n = (I != CJV);
endmodule

// File: tb/tb_am2910.sv
// Directed scoreboard bench for am2910: each vector pushes its expected
// outputs when driven; the owning test pops and compares before the edge.
module tb_am2910;
  import am2910_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  I = 4'd14;
  logic [11:0] D = 12'h000;
  logic        CCEN_n = 1'b0, CC_n = 1'b1, RLD_n = 1'b1, CI = 1'b1, OE_n = 1'b0;
  wire  [11:0] Y;
  wire         FULL_n, PL_n, MAP_n, VECT_n;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  op;
    logic [11:0] d;
    logic        ccen_n, cc_n, rld_n, ci, oe_n;
    logic [11:0] y;
    logic        full_n;
  } vec_t;

  typedef struct packed {
    logic [11:0] y;
    logic        full_n, pl_n, map_n, vect_n;
  } exp_t;

  exp_t exp_q[$];

  am2910 dut (
    .clk(clk), .reset(reset), .I(I), .D(D), .CCEN_n(CCEN_n), .CC_n(CC_n),
    .RLD_n(RLD_n), .CI(CI), .OE_n(OE_n), .Y(Y), .FULL_n(FULL_n),
    .PL_n(PL_n), .MAP_n(MAP_n), .VECT_n(VECT_n)
  );

  always #5 clk = ~clk;

  localparam logic P = 1'b0;  // CC_n value that makes PASS
  localparam logic F = 1'b1;  // CC_n value that makes FAIL

  function automatic vec_t v(logic [3:0] op, logic [11:0] d, logic cc_n,
                             logic [11:0] y, logic full_n = 1'b1, logic ci = 1'b1,
                             logic rld_n = 1'b1, logic oe_n = 1'b0,
                             logic ccen_n = 1'b0);
    vec_t r;
    r.op = op; r.d = d; r.cc_n = cc_n; r.y = y; r.full_n = full_n;
    r.ci = ci; r.rld_n = rld_n; r.oe_n = oe_n; r.ccen_n = ccen_n;
    return r;
  endfunction

  task automatic drive(input vec_t t);
    exp_t e;
    @(negedge clk);
    I = t.op; D = t.d; CCEN_n = t.ccen_n; CC_n = t.cc_n;
    RLD_n = t.rld_n; CI = t.ci; OE_n = t.oe_n;
    e.y      = t.y;
    e.full_n = t.full_n;
    e.pl_n   = (t.op == 4'd2) || (t.op == 4'd6);
    e.map_n  = (t.op != 4'd2);
    e.vect_n = (t.op != 4'd6);
    exp_q.push_back(e);
    #2;
  endtask

  task automatic test_reset();
    vec_t vs[$];
    exp_t e;
    vs = '{v(CONT, 12'h000, F, 12'h000),
           v(LDCT, 12'h007, F, 12'h001),
           v(PUSH, 12'h000, F, 12'h002),
           v(PUSH, 12'h000, F, 12'h003),
           v(PUSH, 12'h000, F, 12'h004),
           v(CONT, 12'h000, F, 12'h000, 1'b1, 1'b0),
           v(CONT, 12'h000, F, 12'h000),
           v(CONT, 12'h000, F, 12'h001),
           v(RPCT, 12'h123, F, 12'h002),
           v(CRTN, 12'h000, P, 12'h000)};
    foreach (vs[k]) begin
      drive(vs[k]);
      if (k == 5) begin reset = 1'b1; #1 reset = 1'b0; end
      e = exp_q.pop_front();
      vectors++;
      if ({Y, FULL_n, PL_n, MAP_n, VECT_n} !== e) begin
        miscompares++;
        $display("FAIL reset[%0d]: Y=%h FULL_n=%b PL_n=%b MAP_n=%b VECT_n=%b, want %h %b %b %b %b",
                 k, Y, FULL_n, PL_n, MAP_n, VECT_n, e.y, e.full_n, e.pl_n, e.map_n, e.vect_n);
      end
      if (k == 0) reset = 1'b0;
    end
  endtask

  task automatic test_cjs_crtn();
    vec_t vs[$];
    exp_t e;
    vs = '{v(CJP,  12'h00F, P, 12'h00F),
           v(CJS,  12'h200, P, 12'h200),
           v(CONT, 12'h000, F, 12'h201),
           v(CRTN, 12'h000, P, 12'h010),
           v(CJS,  12'h300, F, 12'h011),
           v(CRTN, 12'h000, F, 12'h012),
           v(CRTN, 12'h000, P, 12'h010),
           v(CJS,  12'h055, F, 12'h055, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1),
           v(CRTN, 12'h000, P, 12'h011),
           v(JZ,   12'h000, F, 12'h000)};
    foreach (vs[k]) begin
      drive(vs[k]);
      e = exp_q.pop_front();
      vectors++;
      if ({Y, FULL_n, PL_n, MAP_n, VECT_n} !== e) begin
        miscompares++;
        $display("FAIL cjs_crtn[%0d]: Y=%h FULL_n=%b PL_n=%b MAP_n=%b VECT_n=%b, want %h %b %b %b %b",
                 k, Y, FULL_n, PL_n, MAP_n, VECT_n, e.y, e.full_n, e.pl_n, e.map_n, e.vect_n);
      end
    end
  endtask

  task automatic test_counter();
    vec_t vs[$];
    exp_t e;
    vs = '{v(CJP,  12'h03F, P, 12'h03F),
           v(PUSH, 12'h000, F, 12'h040),
           v(LDCT, 12'h003, F, 12'h041),
           v(RFCT, 12'h000, F, 12'h040),
           v(RFCT, 12'h000, F, 12'h040),
           v(RFCT, 12'h000, F, 12'h040),
           v(RFCT, 12'h000, F, 12'h041),
           v(CJS,  12'h100, P, 12'h100),
           v(CRTN, 12'h000, P, 12'h042),
           v(CRTN, 12'h000, P, 12'h042),
           v(RPCT, 12'h1FF, F, 12'h043)};
    foreach (vs[k]) begin
      drive(vs[k]);
      e = exp_q.pop_front();
      vectors++;
      if ({Y, FULL_n, PL_n, MAP_n, VECT_n} !== e) begin
        miscompares++;
        $display("FAIL counter[%0d]: Y=%h FULL_n=%b PL_n=%b MAP_n=%b VECT_n=%b, want %h %b %b %b %b",
                 k, Y, FULL_n, PL_n, MAP_n, VECT_n, e.y, e.full_n, e.pl_n, e.map_n, e.vect_n);
      end
    end
  endtask

  task automatic test_overflow();
    vec_t vs[$];
    exp_t e;
    vs = '{v(JZ,   12'h000, F, 12'h000),
           v(PUSH, 12'h000, F, 12'h001),
           v(PUSH, 12'h000, F, 12'h002),
           v(PUSH, 12'h000, F, 12'h003),
           v(PUSH, 12'h000, F, 12'h004),
           v(PUSH, 12'h000, F, 12'h005),
           v(PUSH, 12'h000, F, 12'h006, 1'b0),
           v(CONT, 12'h000, F, 12'h007, 1'b0),
           v(CRTN, 12'h000, P, 12'h006, 1'b0),
           v(CRTN, 12'h000, P, 12'h004),
           v(CRTN, 12'h000, P, 12'h003),
           v(CRTN, 12'h000, P, 12'h002),
           v(CRTN, 12'h000, P, 12'h001),
           v(CRTN, 12'h000, P, 12'h001),
           v(CONT, 12'h000, F, 12'h002)};
    foreach (vs[k]) begin
      drive(vs[k]);
      e = exp_q.pop_front();
      vectors++;
      if ({Y, FULL_n, PL_n, MAP_n, VECT_n} !== e) begin
        miscompares++;
        $display("FAIL overflow[%0d]: Y=%h FULL_n=%b PL_n=%b MAP_n=%b VECT_n=%b, want %h %b %b %b %b",
                 k, Y, FULL_n, PL_n, MAP_n, VECT_n, e.y, e.full_n, e.pl_n, e.map_n, e.vect_n);
      end
    end
  endtask

  task automatic test_twb();
    vec_t vs[$];
    exp_t e;
    vs = '{v(CJP,  12'h07F, P, 12'h07F),
           v(PUSH, 12'h002, P, 12'h080),
           v(TWB,  12'h3FF, F, 12'h080),
           v(TWB,  12'h3FF, F, 12'h080),
           v(TWB,  12'h3FF, F, 12'h3FF),
           v(PUSH, 12'h001, P, 12'h400),
           v(TWB,  12'h3FF, P, 12'h401),
           v(LOOP, 12'h000, F, 12'h400),
           v(RPCT, 12'h222, F, 12'h401),
           v(LOOP, 12'h000, P, 12'h402)};
    foreach (vs[k]) begin
      drive(vs[k]);
      e = exp_q.pop_front();
      vectors++;
      if ({Y, FULL_n, PL_n, MAP_n, VECT_n} !== e) begin
        miscompares++;
        $display("FAIL twb[%0d]: Y=%h FULL_n=%b PL_n=%b MAP_n=%b VECT_n=%b, want %h %b %b %b %b",
                 k, Y, FULL_n, PL_n, MAP_n, VECT_n, e.y, e.full_n, e.pl_n, e.map_n, e.vect_n);
      end
    end
  endtask

  task automatic test_enables();
    vec_t vs[$];
    exp_t e;
    vs = '{v(JMAP, 12'h123, F, 12'h123),
           v(CJV,  12'h0C0, P, 12'h0C0),
           v(CJV,  12'h0D0, F, 12'h0C1),
           v(LDCT, 12'h009, F, 12'h0C2),
           v(RPCT, 12'h005, F, 12'h005, 1'b1, 1'b1, 1'b0),
           v(JRP,  12'h111, F, 12'h005),
           v(JSRP, 12'h222, F, 12'h005),
           v(JRP,  12'h333, P, 12'h333),
           v(CRTN, 12'h000, P, 12'h006),
           v(CONT, 12'h000, F, 12'hzzz, 1'b1, 1'b1, 1'b1, 1'b1),
           v(CONT, 12'h000, F, 12'hzzz, 1'b1, 1'b1, 1'b1, 1'b1),
           v(CONT, 12'h000, F, 12'h009),
           v(CJP,  12'hFFF, P, 12'hFFF),
           v(CONT, 12'h000, F, 12'h000)};
    foreach (vs[k]) begin
      drive(vs[k]);
      e = exp_q.pop_front();
      vectors++;
      if ({Y, FULL_n, PL_n, MAP_n, VECT_n} !== e) begin
        miscompares++;
        $display("FAIL enables[%0d]: Y=%h FULL_n=%b PL_n=%b MAP_n=%b VECT_n=%b, want %h %b %b %b %b",
                 k, Y, FULL_n, PL_n, MAP_n, VECT_n, e.y, e.full_n, e.pl_n, e.map_n, e.vect_n);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cjs_crtn();
    test_counter();
    test_overflow();
    test_twb();
    test_enables();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/am2910.md
# am2910

Microprogram sequencer for the micro-BESM control store, modelled on the Am2910. Each cycle it produces the next microinstruction address from one of four sources: external D, register/counter R, microprogram counter uPC, or a 5-deep return stack. That address fetches the control word whose fields drive the am2901 slice I, Aadd and Badd inputs. Its condition input is fed back from the slices' status outputs (F30, C4, OVR, F3) through an external test multiplexer.

## Interface
- WIDTH, 12: address/data width of D, Y, R, uPC and stack entries.
- DEPTH, 5: number of stack entries.
- clk  input  1  Clock. All state updates on the rising edge.
- reset  input  1  Asynchronous, active-high reset.
- I  input  4  Sequencer instruction, from the pipeline register.
- D  input  WIDTH  Direct branch address / counter load value.
- CCEN_n  input  1  Condition-code enable, active low.
- CC_n  input  1  Condition code, active low.
- RLD_n  input  1  Unconditional R load from D, active low.
- CI  input  1  Incrementer carry-in. The uPC register loads Y+CI.
- OE_n  input  1  Y output enable, active low. Y is 'z when high.
- Y  output  WIDTH  Next microaddress.
- FULL_n  output  1  Low when the stack holds DEPTH entries.
- PL_n  output  1  Pipeline-register D-source enable, active low.
- MAP_n  output  1  Mapping-PROM enable. Low only for JMAP.
- VECT_n  output  1  Interrupt-vector enable. Low only for CJV.

## Operation
- PASS = CCEN_n | ~CC_n. FAIL = ~PASS.
- Y, PL_n, MAP_n and VECT_n are combinational from I, PASS, D and state.
- PL_n is low for every opcode except 2 and 6.
- Every clock: uPC <= Y + CI, mod 2^WIDTH. Y is the internally selected address, independent of OE_n.
- If RLD_n = 0, R <= D. This overrides any decrement or conditional load.
- Opcodes (Y source; stack action; R action):
  - 0 JZ: 0; SP cleared.
  - 1 CJS: PASS ? D : uPC; push uPC if PASS.
  - 2 JMAP: D.
  - 3 CJP: PASS ? D : uPC.
  - 4 PUSH: uPC; push uPC; R <= D if PASS.
  - 5 JSRP: PASS ? D : R; push uPC.
  - 6 CJV: PASS ? D : uPC.
  - 7 JRP: PASS ? D : R.
  - 8 RFCT: R≠0 ? top : uPC; R≠0 ? R-- : pop.
  - 9 RPCT: R≠0 ? D : uPC; R-- if R≠0.
  - 10 CRTN: PASS ? top : uPC; pop if PASS.
  - 11 CJPP: PASS ? D : uPC; pop if PASS.
  - 12 LDCT: uPC; R <= D.
  - 13 LOOP: PASS ? uPC : top; pop if PASS.
  - 14 CONT: uPC.
  - 15 TWB:
    - PASS: Y = uPC; pop; R-- if R≠0.
    - FAIL, R≠0: Y = top; R--.
    - FAIL, R=0: Y = D; pop.
- Stack:
  - Entry 'top' is stack[SP-1].
  - Push writes stack[SP] and increments SP.
  - Push when SP = DEPTH overwrites stack[DEPTH-1]; SP stays at DEPTH.
  - Pop when SP = 0 is a no-op.
  - Reading top while empty returns stack[0].
- R decrement never wraps, because it is gated by R≠0.

## Timing
- Y is valid combinationally within the cycle that I, D and CC are presented. No added latency.
- uPC, R, SP and the stack update at posedge clk.
- A push and a pop are never both requested in one cycle.
- FULL_n is registered-state derived. It changes the cycle after the push that fills the stack.
- Reset (asynchronous, any time, including mid-loop): uPC = 0, R = 0, SP = 0, all stack entries = 0.
- Output values during reset, and after reset with I = 14, OE_n = 0: Y = 0, FULL_n = 1, PL_n = 0, MAP_n = 1, VECT_n = 1.

## Structure
- Package am2910_pkg:
  - Enum of the 16 opcodes (JZ … TWB).
  - localparams for WIDTH and DEPTH defaults.
- Sub-module am2910_stack:
  - Parameterised LIFO with push, pop and clear.
  - Outputs top and full.
  - Handles the overflow and underflow rules above.
- Top level contains the PASS logic, the opcode decode (always_comb unique case), and the R and uPC registers.

## Test plan
- Reset sequence: assert reset mid-cycle with SP = 3, R = 7 → SP = 0, R = 0, Y = 0 under CONT. Next clock gives Y = 0, then 1 with CI = 1.
- CJS/CRTN round trip:
  - At uPC = 0x010, CJS with PASS and D = 0x200 → Y = 0x200, stack top = 0x010.
  - Later CRTN with PASS → Y = 0x010, SP back to 0.
  - Repeat with FAIL → Y = uPC, no push.
- Counter loop: LDCT with D = 3, then RFCT at a fixed address with top = 0x040 → Y = 0x040 for 3 passes (R = 2, 1, 0). The fourth pass gives Y = uPC and pops.
- Stack overflow/underflow:
  - Six pushes of 0x001..0x006 → FULL_n low after the fifth, top = 0x006, SP = 5.
  - Six pops → the sixth leaves SP = 0.
- TWB, all three branches with D = 0x3FF and top = 0x080:
  - R = 2, FAIL → Y = 0x080, R = 1.
  - R = 0, FAIL → Y = 0x3FF, pop.
  - PASS → Y = uPC, pop.
- Enables and RLD_n:
  - JMAP → MAP_n = 0, PL_n = 1.
  - CJV → VECT_n = 0.
  - RLD_n = 0 during RPCT with D = 0x005 → R = 5, not decremented.
  - OE_n = 1 → Y = 'z while uPC still advances.
